// File: rtl/ambi_core.sv
// ambi_core -- single-cycle accumulator CPU core of the teaching SoC.
//
// Executes one instruction per clock. The instruction {opcode, operand} is
// fetched combinationally from an external instruction memory at address pc.
// Data operands arrive combinationally as ddatain = dmem[operand]. Stores
// present accum as write data with we asserted, and the external data memory
// captures it on the same clock edge. The core holds no memories.
//
// Ports:
//   clk      in   1         single clock, all state updates on posedge
//   rst_n    in   1         synchronous active-low reset
//   pc       out  ADDR_W    instruction address (registered)
//   accum    out  DATA_W    accumulator (registered), also the store data
//   opcode   in   OPCODE_W  opcode of imem[pc]
//   operand  in   ADDR_W    operand of imem[pc], an address or an immediate
//   we       out  1         data-memory write enable (combinational)
//   ddatain  in   DATA_W    dmem[operand], read combinationally
module ambi_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   accum,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ADDR_W-1:0]   operand,
  output logic                we,
  input  logic [DATA_W-1:0]   ddatain
);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(4'h9);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(4'hA);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(4'hB);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4'hC);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(4'hD);
  localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(4'hF);

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              we_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [DATA_W-1:0] imm_s;

  // Sequential pc increment wraps naturally at the top of the address space.
  assign pc_inc_s = pc_q + ADDR_W'(1);
  // Immediate is the operand zero-extended to the data width.
  assign imm_s    = DATA_W'(operand);

  // Instruction decode: next pc, next accumulator and the store strobe.
  always_comb begin
    pc_d  = pc_inc_s;
    acc_d = acc_q;
    we_s  = 1'b0;
    case (opcode)
      OP_NOP:  begin end
      OP_LD:   acc_d = ddatain;
      OP_ST:   we_s  = 1'b1;
      OP_ADD:  acc_d = acc_q + ddatain;
      OP_SUB:  acc_d = acc_q - ddatain;
      OP_AND:  acc_d = acc_q & ddatain;
      OP_OR:   acc_d = acc_q | ddatain;
      OP_XOR:  acc_d = acc_q ^ ddatain;
      OP_NOT:  acc_d = ~acc_q;
      OP_SHL:  acc_d = {acc_q[DATA_W-2:0], 1'b0};
      OP_SHR:  acc_d = {1'b0, acc_q[DATA_W-1:1]};
      OP_LDI:  acc_d = imm_s;
      OP_ADDI: acc_d = acc_q + imm_s;
      OP_JMP:  pc_d  = operand;
      // Branch condition uses the accumulator as it stands before the edge.
      OP_JZ: begin
        if (acc_q == {DATA_W{1'b0}}) begin
          pc_d = operand;
        end else begin
          pc_d = pc_inc_s;
        end
      end
      // HALT re-fetches itself forever; only reset leaves this state.
      OP_HALT: pc_d = pc_q;
      default: begin
        pc_d  = pc_inc_s;
        acc_d = acc_q;
        we_s  = 1'b0;
      end
    endcase
  end

  // Architectural state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= {ADDR_W{1'b0}};
      acc_q <= {DATA_W{1'b0}};
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

  // Reset must suppress a store that is in flight on the same edge.
  assign we    = we_s & rst_n;
  assign pc    = pc_q;
  assign accum = acc_q;

endmodule

// File: tb/tb_ambi_core.sv
// Self-checking bench for ambi_core. Directed instructions are driven on the
// falling edge; each one pushes its hand-computed post-edge state into a
// scoreboard queue. A separate monitor samples we at the rising edge, then pc,
// accum and (optionally) a data-memory word just after it, and compares.
module tb_ambi_core;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic [15:0] accum;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        we;
  logic [15:0] ddatain;

  ambi_core #(.DATA_W(16), .ADDR_W(8), .OPCODE_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .accum   (accum),
    .opcode  (opcode),
    .operand (operand),
    .we      (we),
    .ddatain (ddatain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory model: async read, write on posedge when we=1.
  logic [15:0] dmem [256];
  logic        loaded = 1'b0;
  assign ddatain = dmem[operand];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
      dmem[0] <= 16'h0003;
      dmem[1] <= 16'h0005;
      loaded  <= 1'b1;
    end else if (we) begin
      dmem[operand] <= accum;
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  pc;
    logic [15:0] acc;
    logic        we;
    logic        chk_m;
    logic [7:0]  m_addr;
    logic [15:0] m_val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Monitor: every rising edge with a pending expectation is checked.
  initial begin
    exp_t e;
    logic we_at_edge;
    forever begin
      @(posedge clk);
      we_at_edge = we;
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp({e.name, ".pc"},  {24'd0, pc},    {24'd0, e.pc});
        cmp({e.name, ".acc"}, {16'd0, accum}, {16'd0, e.acc});
        cmp({e.name, ".we"},  {31'd0, we_at_edge}, {31'd0, e.we});
        if (e.chk_m) begin
          cmp({e.name, ".dmem"}, {16'd0, dmem[e.m_addr]}, {16'd0, e.m_val});
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst_v, input logic [3:0] op,
                      input logic [7:0] opd, input logic [7:0] xpc,
                      input logic [15:0] xacc, input logic xwe);
    exp_t e;
    @(negedge clk);
    rst_n   = rst_v;
    opcode  = op;
    operand = opd;
    e.name = nm; e.pc = xpc; e.acc = xacc; e.we = xwe;
    e.chk_m = 1'b0; e.m_addr = 8'h00; e.m_val = 16'h0000;
    sb_q.push_back(e);
  endtask

  task automatic step_m(input string nm, input logic rst_v, input logic [3:0] op,
                        input logic [7:0] opd, input logic [7:0] xpc,
                        input logic [15:0] xacc, input logic xwe,
                        input logic [7:0] maddr, input logic [15:0] mval);
    exp_t e;
    @(negedge clk);
    rst_n   = rst_v;
    opcode  = op;
    operand = opd;
    e.name = nm; e.pc = xpc; e.acc = xacc; e.we = xwe;
    e.chk_m = 1'b1; e.m_addr = maddr; e.m_val = mval;
    sb_q.push_back(e);
  endtask

  initial begin
    int budget;
    rst_n   = 1'b0;
    opcode  = 4'h0;
    operand = 8'h00;

    // Reset and free-running NOPs
    step("reset", 1'b0, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);
    step("nop1",  1'b1, 4'h0, 8'h00, 8'h01, 16'h0000, 1'b0);
    step("nop2",  1'b1, 4'h0, 8'h00, 8'h02, 16'h0000, 1'b0);
    step("nop3",  1'b1, 4'h0, 8'h00, 8'h03, 16'h0000, 1'b0);
    // LD / ADD / ST
    step("ld0",   1'b1, 4'h1, 8'h00, 8'h04, 16'h0003, 1'b0);
    step("add1",  1'b1, 4'h3, 8'h01, 8'h05, 16'h0008, 1'b0);
    step_m("st2", 1'b1, 4'h2, 8'h02, 8'h06, 16'h0008, 1'b1, 8'h02, 16'h0008);
    // LD / SUB / SHL / NOT, then logic ops and SHR
    step("ld1",   1'b1, 4'h1, 8'h01, 8'h07, 16'h0005, 1'b0);
    step("sub0",  1'b1, 4'h4, 8'h00, 8'h08, 16'h0002, 1'b0);
    step("shl",   1'b1, 4'h9, 8'h00, 8'h09, 16'h0004, 1'b0);
    step("not",   1'b1, 4'h8, 8'h00, 8'h0A, 16'hFFFB, 1'b0);
    step("and1",  1'b1, 4'h5, 8'h01, 8'h0B, 16'h0001, 1'b0);
    step("or0",   1'b1, 4'h6, 8'h00, 8'h0C, 16'h0003, 1'b0);
    step("xor2",  1'b1, 4'h7, 8'h02, 8'h0D, 16'h000B, 1'b0);
    step("shr",   1'b1, 4'hA, 8'h00, 8'h0E, 16'h0005, 1'b0);
    // Branches
    step("ldi0",  1'b1, 4'hB, 8'h00, 8'h0F, 16'h0000, 1'b0);
    step("jz_tk", 1'b1, 4'hE, 8'h10, 8'h10, 16'h0000, 1'b0);
    step("ldi1",  1'b1, 4'hB, 8'h01, 8'h11, 16'h0001, 1'b0);
    step("jz_nt", 1'b1, 4'hE, 8'h10, 8'h12, 16'h0001, 1'b0);
    step("jmp05", 1'b1, 4'hD, 8'h05, 8'h05, 16'h0001, 1'b0);
    // Arithmetic wrap and pc wrap
    step("ldi00", 1'b1, 4'hB, 8'h00, 8'h06, 16'h0000, 1'b0);
    step("notff", 1'b1, 4'h8, 8'h00, 8'h07, 16'hFFFF, 1'b0);
    step("addi",  1'b1, 4'hC, 8'hFF, 8'h08, 16'h00FE, 1'b0);
    step("jmpff", 1'b1, 4'hD, 8'hFF, 8'hFF, 16'h00FE, 1'b0);
    step("pcwrap",1'b1, 4'h0, 8'h00, 8'h00, 16'h00FE, 1'b0);
    // HALT holds pc and acc
    for (int i = 0; i < 5; i++) begin
      step("halt", 1'b1, 4'hF, 8'h00, 8'h00, 16'h00FE, 1'b0);
    end
    // Reset during ST suppresses the write
    step("ldi77", 1'b1, 4'hB, 8'h77, 8'h01, 16'h0077, 1'b0);
    step_m("rst_st", 1'b0, 4'h2, 8'h03, 8'h00, 16'h0000, 1'b0, 8'h03, 16'h0000);
    step("post",  1'b1, 4'h0, 8'h00, 8'h01, 16'h0000, 1'b0);

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
